decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, giving the register value, PC and immediate width; legal values are 32 or more.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: fetch offers an instruction.
REQ-005 SHALL have port in_ready, output, 1 bit: the stage accepts the offered instruction this cycle.
REQ-006 SHALL have port instr, input, 32 bits: the RV32I instruction word.
REQ-007 SHALL have port pc, input, DATAWIDTH bits: the instruction address.
REQ-008 SHALL have ports readReg1 and readReg2, outputs, 5 bits each: register-file read addresses, equal to instr[19:15] and instr[24:20] combinationally.
REQ-009 SHALL have ports readData1 and readData2, inputs, DATAWIDTH bits each: register-file read data.
REQ-010 SHALL have ports wb_write (1), wb_reg (5) and wb_data (DATAWIDTH), inputs: the writeback write currently presented to the register file.
REQ-011 SHALL have port flush, input, 1 bit: squash the instruction held in the stage.
REQ-012 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: downstream handshake.
REQ-013 SHALL have registered outputs out_pc (DATAWIDTH), out_rs1_val (DATAWIDTH), out_rs2_val (DATAWIDTH), out_imm (DATAWIDTH), out_rd (5), out_opcode (7), out_funct3 (3), out_funct7 (7) and out_illegal (1).

Function
REQ-014 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-015 SHALL capture all decoded fields on the clock edge where in_valid && in_ready && !flush, and set out_valid=1, giving a latency of 1 cycle.
REQ-016 SHALL clear out_valid when out_ready=1 and no capture occurs; SHALL hold every output stable while out_valid=1 and out_ready=0.
REQ-017 SHALL give flush priority over everything: on that edge out_valid goes to 0 and no capture occurs, even if in_valid=1 and out_ready=1.
REQ-018 SHALL capture out_rs1_val and out_rs2_val as 0 whenever the corresponding source register is x0, regardless of the read data.
REQ-019 SHALL generate out_imm as follows, sign-extended from instr[31] to DATAWIDTH:
- I-type (opcodes 0010011, 0000011, 1100111, 1110011): instr[31:20].
- S-type (0100011): {instr[31:25], instr[11:7]}.
- B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U-type (0110111, 0010111): {instr[31:12], 12'b0}.
- J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- R-type (0110011) and all other opcodes: 0.
REQ-020 SHALL set out_illegal=1 for any opcode not listed in REQ-019 or for instr[1:0] != 2'b11; out_imm SHALL be 0 in that case, and the instruction is still passed through with out_valid.
REQ-021 SHALL capture out_rd = instr[11:7], out_opcode = instr[6:0], out_funct3 = instr[14:12] and out_funct7 = instr[31:25] unconditionally on capture.
REQ-022 SHALL never modify outputs while out_valid=0 except on a capture edge.

Reset
REQ-023 SHALL force, while rst_n=0 and independent of clk, out_valid=0, out_illegal=0, and all data outputs to 0.
REQ-024 SHALL discard any held instruction when reset is asserted mid-operation; in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-025 SHALL use macro DECODE_WB_FORWARD_EN to control writeback forwarding.
REQ-026 SHALL, when DECODE_WB_FORWARD_EN is defined: if wb_write=1, wb_reg equals the source register, and the source register is not 0, capture wb_data instead of readData for that operand, with both operands checked independently.
REQ-027 SHALL, when DECODE_WB_FORWARD_EN is undefined: capture readData1/readData2 directly (subject to REQ-018), and leave the wb_* ports unused.

Verification
REQ-028 Bench SHALL drive instr=0x00500093 (addi x1,x0,5) with in_valid=1 and out_ready=1 -> next cycle out_valid=1, out_imm=5, out_rd=1, out_rs1_val=0.
REQ-029 Bench SHALL drive instr=0xFE000EE3 (beq, offset -4) -> out_imm=0xFFFFFFFC; and instr=0x12345037 (lui) -> out_imm=0x12345000.
REQ-030 Bench SHALL hold out_ready=0 with out_valid=1 and present a new instr -> in_ready=0, outputs unchanged for 5 cycles; then release out_ready -> new instruction is captured on the following edge.
REQ-031 Bench SHALL assert flush together with in_valid=1 and out_ready=1 -> out_valid=0 next cycle and the instruction is not captured.
REQ-032 Bench SHALL, with DECODE_WB_FORWARD_EN defined, set wb_write=1, wb_reg=3, wb_data=0xDEADBEEF, readData1=0x11 and rs1=3 -> out_rs1_val=0xDEADBEEF; with wb_reg=0 and rs1=0 -> out_rs1_val=0.
REQ-033 Bench SHALL assert rst_n=0 asynchronously between clock edges while out_valid=1 -> out_valid and all outputs go to 0 immediately; instr=0x0000007F -> out_illegal=1.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode pipeline register with a valid/ready handshake and flush.
// Define DECODE_WB_FORWARD_EN to bypass the in-flight writeback into the source operands.
module decode_stage #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    input  logic [DATAWIDTH-1:0] pc,
    output logic [4:0]           readReg1,
    output logic [4:0]           readReg2,
    input  logic [DATAWIDTH-1:0] readData1,
    input  logic [DATAWIDTH-1:0] readData2,
    input  logic                 wb_write,
    input  logic [4:0]           wb_reg,
    input  logic [DATAWIDTH-1:0] wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_pc,
    output logic [DATAWIDTH-1:0] out_rs1_val,
    output logic [DATAWIDTH-1:0] out_rs2_val,
    output logic [DATAWIDTH-1:0] out_imm,
    output logic [4:0]           out_rd,
    output logic [6:0]           out_opcode,
    output logic [2:0]           out_funct3,
    output logic [6:0]           out_funct7,
    output logic                 out_illegal
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0]           opcode;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic                 legal;
    logic [31:0]          imm32;
    logic [DATAWIDTH-1:0] imm_ext;
    logic [DATAWIDTH-1:0] rs1_val;
    logic [DATAWIDTH-1:0] rs2_val;
    logic                 capture;

    assign opcode   = instr[6:0];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign readReg1 = rs1;
    assign readReg2 = rs2;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        legal = 1'b1;
        imm32 = '0;
        if (instr[1:0] != 2'b11) begin
            legal = 1'b0;
        end else begin
            case (opcode)
                OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                OP_STORE:
                    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                OP_BRANCH:
                    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                OP_LUI, OP_AUIPC:
                    imm32 = {instr[31:12], 12'b0};
                OP_JAL:
                    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                OP_REG:
                    imm32 = '0;
                default:
                    legal = 1'b0;
            endcase
        end
        // Widen to DATAWIDTH by replicating the sign of the 32-bit immediate.
        imm_ext       = {DATAWIDTH{imm32[31]}};
        imm_ext[31:0] = imm32;
    end

`ifdef DECODE_WB_FORWARD_EN
    always_comb begin
        rs1_val = readData1;
        rs2_val = readData2;
        if (wb_write && (wb_reg == rs1)) rs1_val = wb_data;
        if (wb_write && (wb_reg == rs2)) rs2_val = wb_data;
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_write, wb_reg, wb_data};

    always_comb begin
        rs1_val = readData1;
        rs2_val = readData2;
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_imm     <= '0;
            out_rd      <= '0;
            out_opcode  <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_pc      <= pc;
            out_rs1_val <= rs1_val;
            out_rs2_val <= rs2_val;
            out_imm     <= imm_ext;
            out_rd      <= instr[11:7];
            out_opcode  <= opcode;
            out_funct3  <= instr[14:12];
            out_funct7  <= instr[31:25];
            out_illegal <= !legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
